// File: rtl/extend_sign_if.sv
// Immediate-extension bus: decoded immediate field and mode in, registered 32-bit operand out.
//   in        [15:0] immediate field from the instruction
//   mode      [1:0]  00 sign, 01 zero, 10 upper, 11 branch offset
//   in_valid         qualifies in/mode for this cycle
//   out       [31:0] registered extended operand
//   out_valid        out holds a result captured from a valid input
//   out_neg          registered copy of out[31]
//   out_zero         registered, out is all zeros
interface extend_sign_if;
  localparam int unsigned IN_W  = 16;
  localparam int unsigned OUT_W = 32;

  logic [IN_W-1:0]  in;
  logic [1:0]       mode;
  logic             in_valid;
  logic [OUT_W-1:0] out;
  logic             out_valid;
  logic             out_neg;
  logic             out_zero;

  // Decoder side drives the immediate and consumes the operand.
  modport master (
    output in, mode, in_valid,
    input  out, out_valid, out_neg, out_zero
  );

  // Extension unit side.
  modport slave (
    input  in, mode, in_valid,
    output out, out_valid, out_neg, out_zero
  );
endinterface

// File: rtl/extend_sign.sv
// Immediate-extension unit: turns a 16-bit immediate into a registered 32-bit
// ALU / address / branch-target operand, one clock after a valid input.
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   bus   extend_sign_if.slave (in, mode, in_valid -> out, out_valid, out_neg, out_zero)
module extend_sign (
  input  logic              clk,
  input  logic              rst,
  extend_sign_if.slave      bus
);
  localparam int unsigned IN_W  = 16;
  localparam int unsigned OUT_W = 32;

  localparam logic [1:0] MODE_SIGN   = 2'b00;
  localparam logic [1:0] MODE_ZERO   = 2'b01;
  localparam logic [1:0] MODE_UPPER  = 2'b10;
  localparam logic [1:0] MODE_BRANCH = 2'b11;

  logic [OUT_W-1:0] w_ext;
  logic [OUT_W-1:0] r_out;
  logic             r_out_valid;
  logic             r_out_neg;
  logic             r_out_zero;

  // Extension mux; pure bit manipulation, no arithmetic.
  always_comb begin
    w_ext = '0;
    unique case (bus.mode)
      MODE_SIGN:   w_ext = {{(OUT_W-IN_W){bus.in[IN_W-1]}}, bus.in};
      MODE_ZERO:   w_ext = {{(OUT_W-IN_W){1'b0}}, bus.in};
      MODE_UPPER:  w_ext = {bus.in, {(OUT_W-IN_W){1'b0}}};
      MODE_BRANCH: w_ext = {{(OUT_W-IN_W-2){bus.in[IN_W-1]}}, bus.in, 2'b00};
      default:     w_ext = '0;
    endcase
  end

  // Operand and flags load on valid, hold otherwise; out_valid is a one-cycle strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_out_neg   <= 1'b0;
      r_out_zero  <= 1'b1;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_out      <= w_ext;
        r_out_neg  <= w_ext[OUT_W-1];
        r_out_zero <= (w_ext == '0);
      end
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = r_out_valid;
  assign bus.out_neg   = r_out_neg;
  assign bus.out_zero  = r_out_zero;
endmodule

// File: tb/tb_extend_sign.sv
// Directed self-checking bench for extend_sign.
module tb_extend_sign;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  extend_sign_if u_if ();

  extend_sign u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_out, input logic e_vld,
                         input logic e_neg, input logic e_zero);
    chk({tag, ".out"},       u_if.out,              e_out);
    chk({tag, ".out_valid"}, 32'(u_if.out_valid),   32'(e_vld));
    chk({tag, ".out_neg"},   32'(u_if.out_neg),     32'(e_neg));
    chk({tag, ".out_zero"},  32'(u_if.out_zero),    32'(e_zero));
  endtask

  // Present a valid input at the falling edge, sample just after the next rising edge.
  task automatic apply(input logic [15:0] v_in, input logic [1:0] v_mode);
    @(negedge clk);
    u_if.in       = v_in;
    u_if.mode     = v_mode;
    u_if.in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset held with a valid input present.
    rst           = 1'b0;
    u_if.in       = 16'hFFFF;
    u_if.mode     = 2'b00;
    u_if.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 32'h0000_0000, 1'b0, 1'b0, 1'b1);

    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_all("release", 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);

    apply(16'h9111, 2'b00); chk_all("sext_neg", 32'hFFFF_9111, 1'b1, 1'b1, 1'b0);
    apply(16'h7FFF, 2'b00); chk_all("sext_pos", 32'h0000_7FFF, 1'b1, 1'b0, 1'b0);
    apply(16'h9111, 2'b01); chk_all("zext",     32'h0000_9111, 1'b1, 1'b0, 1'b0);
    apply(16'h9111, 2'b10); chk_all("upper",    32'h9111_0000, 1'b1, 1'b1, 1'b0);
    apply(16'hFFFF, 2'b11); chk_all("br_neg",   32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
    apply(16'h0001, 2'b11); chk_all("br_pos",   32'h0000_0004, 1'b1, 1'b0, 1'b0);
    apply(16'h0000, 2'b11); chk_all("br_zero",  32'h0000_0000, 1'b1, 1'b0, 1'b1);
    apply(16'h8000, 2'b11); chk_all("br_min",   32'hFFFE_0000, 1'b1, 1'b1, 1'b0);
    apply(16'h0000, 2'b10); chk_all("upper_z",  32'h0000_0000, 1'b1, 1'b0, 1'b1);

    // Back-to-back pipeline.
    apply(16'h0001, 2'b00); chk_all("pipe0", 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    apply(16'h8000, 2'b00); chk_all("pipe1", 32'hFFFF_8000, 1'b1, 1'b1, 1'b0);
    apply(16'h1234, 2'b10); chk_all("pipe2", 32'h1234_0000, 1'b1, 1'b0, 1'b0);

    // Hold with in_valid low; garbage mode and input must be ignored.
    @(negedge clk);
    u_if.in_valid = 1'b0;
    u_if.in       = 16'h0000;
    u_if.mode     = 2'bxx;
    @(posedge clk);
    #1;
    chk_all("hold1", 32'h1234_0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("hold2", 32'h1234_0000, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a valid burst.
    apply(16'hABCD, 2'b00); chk_all("burst", 32'hFFFF_ABCD, 1'b1, 1'b1, 1'b0);
    u_if.in = 16'h5555;
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_rst", 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk_all("rst_held", 32'h0000_0000, 1'b0, 1'b0, 1'b1);

    // First edge after release produces a fresh result.
    @(negedge clk);
    rst = 1'b1;
    u_if.in       = 16'h4321;
    u_if.mode     = 2'b01;
    u_if.in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_rst", 32'h0000_4321, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    u_if.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_all("post_rst_hold", 32'h0000_4321, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
